// File: rtl/reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_pkg : shared helpers for the reg_pipe register pipeline          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_pkg;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_stage : one data register plus valid bit, with enable and flush  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_stage
  import reg_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = INIT;
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = d;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= INIT;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/reg_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_pipe : DEPTH-stage valid-tagged register pipeline with occupancy |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_pipe
  import reg_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                a,
  input  logic                            in_valid,
  input  logic                            en,
  input  logic                            flush,
  output logic [WIDTH-1:0]                y,
  output logic                            y_valid,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            full,
  output logic                            empty
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  if (DEPTH < 1) begin : g_bad_depth
    $error("reg_pipe: DEPTH must be at least 1");
  end

  stage_t           stage_in [DEPTH];
  logic [WIDTH-1:0] q_data   [DEPTH];
  logic [DEPTH-1:0] q_valid;

  // Stage 0 takes the external input; every later stage takes its predecessor.
  always_comb begin
    stage_in[0].valid = in_valid;
    stage_in[0].data  = a;
    for (int i = 1; i < DEPTH; i++) begin
      stage_in[i].valid = q_valid[i-1];
      stage_in[i].data  = q_data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    reg_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .d       (stage_in[g].data),
      .d_valid (stage_in[g].valid),
      .q       (q_data[g]),
      .q_valid (q_valid[g])
    );
  end

  logic [CW-1:0] count_d, count_q;

  // Entry and exit on the same edge cancel; exit uses the pre-edge last valid.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(in_valid) - CW'(q_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && en && !flush) begin
      assert ((int'(count_q) + int'(in_valid) - int'(q_valid[DEPTH-1])) inside {[0:DEPTH]})
        else $error("reg_pipe: occupancy out of range");
    end
  end

  assign y       = q_data[DEPTH-1];
  assign y_valid = q_valid[DEPTH-1];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_pipe : scoreboard bench for reg_pipe (WIDTH=8 DEPTH=3 INIT=3) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reg_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] INIT  = 8'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] a;
  logic       in_valid;
  logic       en;
  logic       flush;
  logic [7:0] y;
  logic       y_valid;
  logic [1:0] count;
  logic       full;
  logic       empty;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clock = ~clock;

  reg_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .in_valid (in_valid),
    .en       (en),
    .flush    (flush),
    .y        (y),
    .y_valid  (y_valid),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs for the next edge; accepted valid data is queued as expected output.
  task automatic drive(input logic [7:0] d, input logic iv, input logic e, input logic f);
    a        = d;
    in_valid = iv;
    en       = e;
    flush    = f;
    if (f) exp_q.delete();
    else if (e && iv) exp_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input int ey, input int ev, input int ec);
    chk({tag, "_y"},     y,       ey);
    chk({tag, "_valid"}, y_valid, ev);
    chk({tag, "_count"}, count,   ec);
    chk({tag, "_full"},  full,    (ec == DEPTH) ? 1 : 0);
    chk({tag, "_empty"}, empty,   (ec == 0) ? 1 : 0);
  endtask

  // An entry leaves the pipe on any enabled, unflushed edge while y_valid is high.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && y_valid === 1'b1 && en === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got y=%0d expected no output", y);
        end else begin
          exp_v = exp_q.pop_front();
          chk("out_y", y, exp_v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    a        = 8'd9;
    in_valid = 1'b1;
    en       = 1'b1;
    flush    = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    chk_state("in_reset", 3, 0, 0);

    en       = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk_state("post_reset", 3, 0, 0);

    // Fill the pipe, then shift once more while full.
    drive(8'd9, 1, 1, 0);  tick(); chk("fill1_count", count, 1);
    drive(8'd10, 1, 1, 0); tick(); chk("fill2_count", count, 2);
    drive(8'd11, 1, 1, 0); tick(); chk_state("fill3", 9, 1, 3);
    drive(8'd12, 1, 1, 0); tick(); chk_state("full_shift", 10, 1, 3);

    // Stall with toggling input: nothing may move.
    for (int i = 0; i < 5; i++) begin
      drive((i % 2) ? 8'd255 : 8'd0, 1, 0, 0);
      tick();
      chk_state("stall", 10, 1, 3);
    end
    drive(8'd13, 1, 1, 0); tick(); chk_state("resume", 11, 1, 3);

    // Flush beats en; the 7 must not be captured.
    drive(8'd7, 1, 1, 1); tick(); chk_state("flush", 3, 0, 0);

    // One valid entry followed by bubbles.
    drive(8'd5, 1, 1, 0); tick(); chk("bub1_count", count, 1);
    drive(8'd0, 0, 1, 0); tick(); chk("bub2_count", count, 1);
    drive(8'd0, 0, 1, 0); tick(); chk_state("bub3", 5, 1, 1);
    drive(8'd0, 0, 1, 0); tick(); chk_state("bub4", 0, 0, 0);

    // Mid-cycle asynchronous reset while full.
    drive(8'd20, 1, 1, 0); tick();
    drive(8'd21, 1, 1, 0); tick();
    drive(8'd22, 1, 1, 0); tick(); chk_state("refill", 20, 1, 3);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_state("async_reset", 3, 0, 0);
    #2;
    reset = 1'b1;
    drive(8'd8, 1, 1, 0); tick(); chk("after_rst_count", count, 1);
    drive(8'd0, 0, 1, 0); tick();
    drive(8'd0, 0, 1, 0); tick(); chk_state("after_rst", 8, 1, 1);

    for (int i = 0; i < DEPTH; i++) begin
      drive(8'd0, 0, 1, 0);
      tick();
    end
    chk_state("drained", 0, 0, 0);
    chk("queue_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
